// File: rtl/ram_bus_master_if.sv
// Request/response channel bundle between the load/store unit and the RAM bus master.
// The "master" modport is the requester side; the "slave" modport is the bus master block.
interface ram_bus_master_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_we;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_we, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_we, resp_rdata
  );

endinterface

// File: rtl/ram_bus_master.sv
// Single-transaction initiator for an asynchronous single-port RAM chip.
// A request is latched in IDLE, presented on the chip strobes for WAIT_STATES+1
// cycles in ACCESS, and its completion is held in RESP until the consumer takes it.
// All RAM-side outputs decode from the state and the latched request only, so the
// request inputs never reach the chip pins combinationally.
module ram_bus_master #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_bus_master_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  accept;
  logic                  capture;

  logic                  op_we;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [3:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] rdata;

  // State register; reset always lands in IDLE, abandoning any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the one-cycle accept/capture strobes for the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          capture    = ~op_we;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latched request, wait-state countdown and the read-data holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      wait_cnt <= 4'd0;
      rdata    <= '0;
    end else begin
      if (accept) begin
        op_we    <= bus.req_we;
        op_addr  <= bus.req_addr;
        op_wdata <= bus.req_wdata;
        wait_cnt <= WAIT_INIT;
      end else if ((state == ACCESS) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (capture) begin
        rdata <= ram_data;
      end
    end
  end

  // Chip side: strobes only in ACCESS; the bus is driven only while writing.
  assign ram_cs   = (state == ACCESS);
  assign ram_we   = ram_cs & op_we;
  assign ram_oe   = ram_cs & ~op_we;
  assign ram_addr = op_addr;
  assign ram_data = ram_we ? op_wdata : 'z;

  // Requester side: ready is masked during the reset cycle itself.
  assign bus.req_ready  = (state == IDLE) & ~reset;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_we    = op_we;
  assign bus.resp_rdata = rdata;

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master: one instance with no wait states and one
// with three, each attached to a behavioural RAM chip and a bus-idle pull probe.
module tb_ram_bus_master;

  localparam int AW = 14;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]    req_valid_v;
  logic [1:0]    req_we_v;
  logic [1:0]    resp_ready_v;
  logic [AW-1:0] req_addr_v  [2];
  logic [DW-1:0] req_wdata_v [2];

  wire           req_ready_v  [2];
  wire           resp_valid_v [2];
  wire           resp_we_v    [2];
  wire [DW-1:0]  resp_rdata_v [2];
  wire           ram_cs_v     [2];
  wire           ram_we_v     [2];
  wire           ram_oe_v     [2];
  wire [AW-1:0]  ram_addr_v   [2];
  wire [DW-1:0]  ram_data_v   [2];
  wire [31:0]    cs_count_v   [2];
  wire [31:0]    overlap_v    [2];
  wire [31:0]    idle_drive_v [2];
  wire [31:0]    read_fight_v [2];

  int vectors    = 0;
  int miscompares = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            cs_cycles  = 0;
    int            overlap    = 0;
    int            idle_drive = 0;
    int            read_fight = 0;

    ram_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    ram_bus_master #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .WAIT_STATES((g == 0) ? 0 : 3)
    ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bif),
      .ram_addr(ram_addr),
      .ram_data(ram_data),
      .ram_cs  (ram_cs),
      .ram_we  (ram_we),
      .ram_oe  (ram_oe)
    );

    assign bif.req_valid  = req_valid_v[g];
    assign bif.req_we     = req_we_v[g];
    assign bif.req_addr   = req_addr_v[g];
    assign bif.req_wdata  = req_wdata_v[g];
    assign bif.resp_ready = resp_ready_v[g];

    assign req_ready_v[g]  = bif.req_ready;
    assign resp_valid_v[g] = bif.resp_valid;
    assign resp_we_v[g]    = bif.resp_we;
    assign resp_rdata_v[g] = bif.resp_rdata;
    assign ram_cs_v[g]     = ram_cs;
    assign ram_we_v[g]     = ram_we;
    assign ram_oe_v[g]     = ram_oe;
    assign ram_addr_v[g]   = ram_addr;
    assign ram_data_v[g]   = ram_data;
    assign cs_count_v[g]   = cs_cycles;
    assign overlap_v[g]    = overlap;
    assign idle_drive_v[g] = idle_drive;
    assign read_fight_v[g] = read_fight;

    // RAM chip drives its output latch while selected for a read; the probe
    // pulls the bus to zero whenever the chip is deselected, so any master
    // drive in that window shows up as a nonzero or unknown bus value.
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 'z;
    assign ram_data = ram_cs ? 'z : '0;

    // RAM array sampled on the falling edge inside a read access.
    always @(negedge clk) begin
      if (ram_cs === 1'b1 && ram_oe === 1'b1 && ram_we === 1'b0) begin
        ram_q <= mem[ram_addr];
      end
    end

    // RAM commits write data at the rising edge that closes a write cycle.
    always @(posedge clk) begin
      if (ram_cs === 1'b1 && ram_we === 1'b1) begin
        mem[ram_addr] <= ram_data;
      end
    end

    // Bus-discipline monitor over the cycle that just ended.
    always @(posedge clk) begin
      if (ram_cs === 1'b1) cs_cycles <= cs_cycles + 1;
      if (ram_we === 1'b1 && ram_oe === 1'b1) overlap <= overlap + 1;
      if (ram_cs === 1'b0 && ram_data !== '0) idle_drive <= idle_drive + 1;
      if (ram_cs === 1'b1 && ram_oe === 1'b1 && ram_data !== ram_q) read_fight <= read_fight + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present a request and return just after the edge that accepts it.
  task automatic applyStimulus(input int d, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    int waited;
    waited = 0;
    req_we_v[d]    = we;
    req_addr_v[d]  = addr;
    req_wdata_v[d] = wdata;
    req_valid_v[d] = 1'b1;
    while (req_ready_v[d] !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("accept ready", {31'd0, req_ready_v[d]}, 32'd1);
    tick();
    req_valid_v[d] = 1'b0;
  endtask

  // Full transaction with resp_ready held high, checking every cycle of it.
  task automatic doAccess(input int d, input int ws, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic chk_rd,
                          input logic [DW-1:0] exp_rd, input string tag);
    int base;
    applyStimulus(d, we, addr, wdata);
    base = cs_count_v[d];
    for (int i = 0; i <= ws; i++) begin
      checkOutput({tag, " cs"},         {31'd0, ram_cs_v[d]},     32'd1);
      checkOutput({tag, " we"},         {31'd0, ram_we_v[d]},     {31'd0, we});
      checkOutput({tag, " oe"},         {31'd0, ram_oe_v[d]},     {31'd0, !we});
      checkOutput({tag, " addr"},       {18'd0, ram_addr_v[d]},   {18'd0, addr});
      checkOutput({tag, " ready low"},  {31'd0, req_ready_v[d]},  32'd0);
      checkOutput({tag, " no resp"},    {31'd0, resp_valid_v[d]}, 32'd0);
      if (we) checkOutput({tag, " bus wdata"}, {24'd0, ram_data_v[d]}, {24'd0, wdata});
      tick();
    end
    checkOutput({tag, " resp valid"}, {31'd0, resp_valid_v[d]}, 32'd1);
    checkOutput({tag, " resp we"},    {31'd0, resp_we_v[d]},    {31'd0, we});
    checkOutput({tag, " resp cs low"}, {31'd0, ram_cs_v[d]},    32'd0);
    if (chk_rd) checkOutput({tag, " rdata"}, {24'd0, resp_rdata_v[d]}, {24'd0, exp_rd});
    tick();
    checkOutput({tag, " resp done"},  {31'd0, resp_valid_v[d]}, 32'd0);
    checkOutput({tag, " idle ready"}, {31'd0, req_ready_v[d]},  32'd1);
    checkOutput({tag, " cs cycles"},  cs_count_v[d] - base,     ws + 1);
  endtask

  // Directed sequence covering reset, both wait-state settings, backpressure,
  // back-to-back turnaround and reset aborts.
  initial begin
    reset        = 1'b1;
    req_valid_v  = 2'b00;
    req_we_v     = 2'b00;
    resp_ready_v = 2'b11;
    for (int d = 0; d < 2; d++) begin
      req_addr_v[d]  = '0;
      req_wdata_v[d] = '0;
    end

    tick();
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset ready",  {31'd0, req_ready_v[d]},  32'd0);
      checkOutput("reset rvalid", {31'd0, resp_valid_v[d]}, 32'd0);
      checkOutput("reset rwe",    {31'd0, resp_we_v[d]},    32'd0);
      checkOutput("reset rdata",  {24'd0, resp_rdata_v[d]}, 32'd0);
      checkOutput("reset cs",     {31'd0, ram_cs_v[d]},     32'd0);
      checkOutput("reset addr",   {18'd0, ram_addr_v[d]},   32'd0);
    end
    reset = 1'b0;

    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checkOutput("idle ready", {31'd0, req_ready_v[d]}, 32'd1);
        checkOutput("idle cs",    {31'd0, ram_cs_v[d]},    32'd0);
        checkOutput("idle we",    {31'd0, ram_we_v[d]},    32'd0);
        checkOutput("idle oe",    {31'd0, ram_oe_v[d]},    32'd0);
        checkOutput("idle bus",   {24'd0, ram_data_v[d]},  32'd0);
      end
    end

    $display("[TB] zero wait states: write then read 0x010");
    doAccess(0, 0, 1'b1, 14'h0010, 8'hA5, 1'b0, 8'h00, "ws0 wr 010");
    doAccess(0, 0, 1'b0, 14'h0010, 8'h00, 1'b1, 8'hA5, "ws0 rd 010");

    $display("[TB] three wait states: top address");
    doAccess(1, 3, 1'b1, 14'h3FFF, 8'h5A, 1'b0, 8'h00, "ws3 wr 3fff");
    doAccess(1, 3, 1'b0, 14'h3FFF, 8'h00, 1'b1, 8'h5A, "ws3 rd 3fff");

    $display("[TB] response backpressure");
    doAccess(0, 0, 1'b1, 14'h0020, 8'h11, 1'b0, 8'h00, "bp wr 020");
    resp_ready_v[0] = 1'b0;
    applyStimulus(0, 1'b0, 14'h0020, 8'h00);
    tick();
    req_we_v[0]    = 1'b1;
    req_addr_v[0]  = 14'h0021;
    req_wdata_v[0] = 8'h22;
    req_valid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp hold valid", {31'd0, resp_valid_v[0]}, 32'd1);
      checkOutput("bp hold rdata", {24'd0, resp_rdata_v[0]}, 32'h11);
      checkOutput("bp hold ready", {31'd0, req_ready_v[0]},  32'd0);
      checkOutput("bp hold cs",    {31'd0, ram_cs_v[0]},     32'd0);
      tick();
    end
    resp_ready_v[0] = 1'b1;
    checkOutput("bp handshake valid", {31'd0, resp_valid_v[0]}, 32'd1);
    tick();
    checkOutput("bp after hs valid", {31'd0, resp_valid_v[0]}, 32'd0);
    checkOutput("bp after hs ready", {31'd0, req_ready_v[0]},  32'd1);
    checkOutput("bp after hs cs",    {31'd0, ram_cs_v[0]},     32'd0);
    tick();
    req_valid_v[0] = 1'b0;
    checkOutput("bp 2nd cs",    {31'd0, ram_cs_v[0]},   32'd1);
    checkOutput("bp 2nd we",    {31'd0, ram_we_v[0]},   32'd1);
    checkOutput("bp 2nd addr",  {18'd0, ram_addr_v[0]}, 32'h0021);
    checkOutput("bp 2nd bus",   {24'd0, ram_data_v[0]}, 32'h22);
    tick();
    checkOutput("bp 2nd resp",  {31'd0, resp_valid_v[0]}, 32'd1);
    checkOutput("bp 2nd rwe",   {31'd0, resp_we_v[0]},    32'd1);
    checkOutput("bp rdata kept", {24'd0, resp_rdata_v[0]}, 32'h11);
    tick();

    $display("[TB] back-to-back read/write on 0x001");
    doAccess(0, 0, 1'b1, 14'h0001, 8'h3C, 1'b0, 8'h00, "b2b wr 3c");
    doAccess(0, 0, 1'b0, 14'h0001, 8'h00, 1'b1, 8'h3C, "b2b rd 3c");
    doAccess(0, 0, 1'b1, 14'h0001, 8'hFF, 1'b0, 8'h00, "b2b wr ff");
    doAccess(0, 0, 1'b0, 14'h0001, 8'h00, 1'b1, 8'hFF, "b2b rd ff");

    $display("[TB] reset during a four-cycle write");
    doAccess(1, 3, 1'b1, 14'h0100, 8'h77, 1'b0, 8'h00, "abort pre wr");
    applyStimulus(1, 1'b1, 14'h0100, 8'h99);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("abort cs",     {31'd0, ram_cs_v[1]},     32'd0);
    checkOutput("abort we",     {31'd0, ram_we_v[1]},     32'd0);
    checkOutput("abort rvalid", {31'd0, resp_valid_v[1]}, 32'd0);
    checkOutput("abort ready",  {31'd0, req_ready_v[1]},  32'd0);
    reset = 1'b0;
    tick();
    checkOutput("abort idle ready",  {31'd0, req_ready_v[1]},  32'd1);
    checkOutput("abort idle rvalid", {31'd0, resp_valid_v[1]}, 32'd0);
    checkOutput("abort idle cs",     {31'd0, ram_cs_v[1]},     32'd0);
    tick();
    checkOutput("abort no late resp", {31'd0, resp_valid_v[1]}, 32'd0);
    doAccess(1, 3, 1'b0, 14'h0100, 8'h00, 1'b0, 8'h00, "abort rd");
    checkOutput("abort rdata old or new",
                {31'd0, (resp_rdata_v[1] === 8'h77) || (resp_rdata_v[1] === 8'h99)}, 32'd1);

    $display("[TB] reset and request on the same edge");
    reset          = 1'b1;
    req_we_v[0]    = 1'b0;
    req_addr_v[0]  = 14'h0010;
    req_valid_v[0] = 1'b1;
    tick();
    reset          = 1'b0;
    req_valid_v[0] = 1'b0;
    checkOutput("reset wins cs", {31'd0, ram_cs_v[0]}, 32'd0);
    tick();
    checkOutput("reset wins still idle", {31'd0, ram_cs_v[0]},     32'd0);
    checkOutput("reset wins no resp",    {31'd0, resp_valid_v[0]}, 32'd0);

    for (int d = 0; d < 2; d++) begin
      checkOutput("we/oe overlap",   overlap_v[d],    32'd0);
      checkOutput("bus driven idle", idle_drive_v[d], 32'd0);
      checkOutput("read contention", read_fight_v[d], 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
